// File: rtl/ddr3_ui_bridge.sv
// ddr3_ui_bridge: buffers cache-side commands, drives the DDR3 controller user
// interface (single-beat writes, burst reads) and returns read beats through a
// credit-managed response FIFO.
// Optional feature macro DDR_RD_BYPASS_EN: when defined, a read beat arriving
// while the response FIFO is empty and the consumer is ready is forwarded in the
// same cycle without being stored.
// Handshake: a transfer happens on a cycle where valid (or en) and ready (or rdy)
// are both high at the rising clock edge; a valid/en, once raised, holds its
// payload steady until that transfer.
module ddr3_ui_bridge #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 8,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  io_fifo_cmd_valid,
  output logic                  io_fifo_cmd_ready,
  input  logic                  io_fifo_cmd_type,
  input  logic [ADDR_W-1:0]     io_fifo_cmd_addr,
  input  logic [5:0]            io_fifo_cmd_burst_cnt,
  input  logic [DATA_W-1:0]     io_fifo_cmd_wt_data,
  input  logic [DATA_W/8-1:0]   io_fifo_cmd_wt_mask,
  output logic                  io_fifo_rsp_valid,
  input  logic                  io_fifo_rsp_ready,
  output logic [DATA_W-1:0]     io_fifo_rsp_data,
  input  logic                  init_calib_complete,
  input  logic                  app_cmd_rdy,
  output logic                  app_cmd_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [5:0]            app_burst_number,
  input  logic                  app_wdata_rdy,
  output logic                  app_wdata_en,
  output logic                  app_wdata_end,
  output logic [DATA_W-1:0]     app_wdata,
  output logic [DATA_W/8-1:0]   app_wdata_mask,
  input  logic                  app_rd_data_valid,
  input  logic [DATA_W-1:0]     app_rd_data,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            dbg_state
);
  localparam int MW  = DATA_W / 8;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int PW  = RAW + 1;
  localparam int EW  = 1 + ADDR_W + 6 + DATA_W + MW;
  localparam logic [7:0] RSP_DEPTH_C = 8'(RSP_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2} state_t;

  // ---------------- command FIFO ----------------
  logic [EW-1:0]  cmd_mem [CMD_DEPTH];
  logic [CAW:0]   cmd_wp, cmd_rp;
  logic           cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic           h_type;
  logic [ADDR_W-1:0] h_addr;
  logic [5:0]     h_burst;
  logic [DATA_W-1:0] h_data;
  logic [MW-1:0]  h_mask;

  assign cmd_empty = (cmd_wp == cmd_rp);
  assign cmd_full  = (cmd_wp[CAW] != cmd_rp[CAW]) && (cmd_wp[CAW-1:0] == cmd_rp[CAW-1:0]);
  assign io_fifo_cmd_ready = !cmd_full;
  assign cmd_push  = io_fifo_cmd_valid && !cmd_full;
  assign {h_type, h_addr, h_burst, h_data, h_mask} = cmd_mem[cmd_rp[CAW-1:0]];

  // Command storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wp[CAW-1:0]] <= {io_fifo_cmd_type, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt,
                                   io_fifo_cmd_wt_data, io_fifo_cmd_wt_mask};
  end

  // Command FIFO pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
    end
  end

  // ---------------- response FIFO and credit ----------------
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW:0]   rsp_wp, rsp_rp;
  logic [PW-1:0]  rsp_occ, pending;
  logic           rsp_empty, rsp_full, rsp_push, rsp_pop;
  logic           beat_ok, beat_drop, byp;
  logic [7:0]     burst_ext, credit;

  assign rsp_occ   = rsp_wp - rsp_rp;
  assign rsp_empty = (rsp_wp == rsp_rp);
  assign rsp_full  = (rsp_wp[RAW] != rsp_rp[RAW]) && (rsp_wp[RAW-1:0] == rsp_rp[RAW-1:0]);
  assign rsp_pop   = io_fifo_rsp_ready && !rsp_empty;
  assign beat_ok   = app_rd_data_valid && (pending != '0);
`ifdef DDR_RD_BYPASS_EN
  assign byp = beat_ok && rsp_empty && io_fifo_rsp_ready;
`else
  assign byp = 1'b0;
`endif
  // A full FIFO can still take a beat when it is popped in the same cycle.
  assign beat_drop = beat_ok && rsp_full && !rsp_pop;
  assign rsp_push  = beat_ok && !byp && !beat_drop;
  assign io_fifo_rsp_valid = !rsp_empty || byp;
  assign io_fifo_rsp_data  = byp ? app_rd_data : rsp_mem[rsp_rp[RAW-1:0]];

  assign burst_ext = {2'b00, h_burst} + 8'd1;
  assign credit    = RSP_DEPTH_C - 8'(rsp_occ) - 8'(pending);

  // Response storage.
  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wp[RAW-1:0]] <= app_rd_data;
  end

  // ---------------- FSM ----------------
  state_t state, state_n;
  logic   cmd_done, wd_done, cmd_done_n, wd_done_n;
  logic   cmd_en_n, wd_en_n, load, rd_issue, oversize;
  logic   cmd_acc, wd_acc;

  assign cmd_acc = app_cmd_en && app_cmd_rdy;
  assign wd_acc  = app_wdata_en && app_wdata_rdy;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, next strobe values and FIFO pop decisions.
  always_comb begin
    state_n    = state;
    cmd_en_n   = app_cmd_en;
    wd_en_n    = app_wdata_en;
    cmd_done_n = cmd_done;
    wd_done_n  = wd_done;
    cmd_pop    = 1'b0;
    load       = 1'b0;
    rd_issue   = 1'b0;
    oversize   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cmd_empty) begin
          if (h_type && (burst_ext > RSP_DEPTH_C)) begin
            // Can never fit in the response FIFO: drop it and flag.
            cmd_pop  = 1'b1;
            oversize = 1'b1;
          end else if (init_calib_complete) begin
            if (!h_type) begin
              state_n    = S_WR;
              cmd_en_n   = 1'b1;
              wd_en_n    = 1'b1;
              cmd_done_n = 1'b0;
              wd_done_n  = 1'b0;
              load       = 1'b1;
            end else if (burst_ext <= credit) begin
              state_n  = S_RD;
              cmd_en_n = 1'b1;
              load     = 1'b1;
            end
          end
        end
      end
      S_WR: begin
        if (cmd_acc) begin
          cmd_en_n   = 1'b0;
          cmd_done_n = 1'b1;
        end
        if (wd_acc) begin
          wd_en_n   = 1'b0;
          wd_done_n = 1'b1;
        end
        if ((cmd_done || cmd_acc) && (wd_done || wd_acc)) begin
          state_n    = S_IDLE;
          cmd_pop    = 1'b1;
          cmd_done_n = 1'b0;
          wd_done_n  = 1'b0;
        end
      end
      S_RD: begin
        if (cmd_acc) begin
          cmd_en_n = 1'b0;
          state_n  = S_IDLE;
          cmd_pop  = 1'b1;
          rd_issue = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered controller-side outputs, pending-beat counter and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      app_cmd_en       <= 1'b0;
      app_wdata_en     <= 1'b0;
      cmd_done         <= 1'b0;
      wd_done          <= 1'b0;
      app_cmd          <= 3'b000;
      app_addr         <= '0;
      app_burst_number <= 6'd0;
      app_wdata        <= '0;
      app_wdata_mask   <= '0;
      pending          <= '0;
      rsp_wp           <= '0;
      rsp_rp           <= '0;
      err              <= 1'b0;
    end else begin
      app_cmd_en   <= cmd_en_n;
      app_wdata_en <= wd_en_n;
      cmd_done     <= cmd_done_n;
      wd_done      <= wd_done_n;
      if (load) begin
        app_cmd          <= {2'b00, h_type};
        app_addr         <= h_addr;
        app_burst_number <= h_type ? h_burst : 6'd0;
        app_wdata        <= h_data;
        app_wdata_mask   <= h_mask;
      end
      pending <= pending + (rd_issue ? burst_ext[PW-1:0] : '0) - (beat_ok ? PW'(1) : '0);
      if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
      if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
      if (oversize || beat_drop || (app_rd_data_valid && (pending == '0))) err <= 1'b1;
    end
  end

  assign app_wdata_end = app_wdata_en;
  assign busy          = !cmd_empty || (state != S_IDLE) || (pending != '0);
  assign dbg_state     = state;

endmodule

// File: tb/tb_ddr3_ui_bridge.sv
// tb_ddr3_ui_bridge: directed bench for ddr3_ui_bridge. Stimulus tasks push the
// expected controller commands and response beats into queues; a negedge monitor
// pops and compares them whenever the DUT hands something over.
module tb_ddr3_ui_bridge;
  logic         clk = 1'b0;
  logic         rstn;
  logic         io_fifo_cmd_valid, io_fifo_cmd_ready, io_fifo_cmd_type;
  logic [26:0]  io_fifo_cmd_addr;
  logic [5:0]   io_fifo_cmd_burst_cnt;
  logic [127:0] io_fifo_cmd_wt_data;
  logic [15:0]  io_fifo_cmd_wt_mask;
  logic         io_fifo_rsp_valid, io_fifo_rsp_ready;
  logic [127:0] io_fifo_rsp_data;
  logic         init_calib_complete, app_cmd_rdy, app_cmd_en;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic [5:0]   app_burst_number;
  logic         app_wdata_rdy, app_wdata_en, app_wdata_end;
  logic [127:0] app_wdata;
  logic [15:0]  app_wdata_mask;
  logic         app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic         busy, err;
  logic [1:0]   dbg_state;

  ddr3_ui_bridge dut (
    .clk(clk), .rstn(rstn),
    .io_fifo_cmd_valid(io_fifo_cmd_valid), .io_fifo_cmd_ready(io_fifo_cmd_ready),
    .io_fifo_cmd_type(io_fifo_cmd_type), .io_fifo_cmd_addr(io_fifo_cmd_addr),
    .io_fifo_cmd_burst_cnt(io_fifo_cmd_burst_cnt), .io_fifo_cmd_wt_data(io_fifo_cmd_wt_data),
    .io_fifo_cmd_wt_mask(io_fifo_cmd_wt_mask),
    .io_fifo_rsp_valid(io_fifo_rsp_valid), .io_fifo_rsp_ready(io_fifo_rsp_ready),
    .io_fifo_rsp_data(io_fifo_rsp_data),
    .init_calib_complete(init_calib_complete), .app_cmd_rdy(app_cmd_rdy),
    .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_burst_number(app_burst_number), .app_wdata_rdy(app_wdata_rdy),
    .app_wdata_en(app_wdata_en), .app_wdata_end(app_wdata_end), .app_wdata(app_wdata),
    .app_wdata_mask(app_wdata_mask), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int fire_cyc = 0;
  logic [177:0] cmd_exp_q[$];
  logic [127:0] rsp_exp_q[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [177:0] me;
  logic         me_t;
  logic [26:0]  me_a;
  logic [5:0]   me_b;
  logic [127:0] me_d;
  logic [15:0]  me_m;

  // Monitor: compares accepted controller commands and delivered response beats.
  always @(negedge clk) begin
    if (rstn && app_cmd_en && app_cmd_rdy) begin
      n_issued++;
      if (cmd_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd: got cmd %0h addr %0h, required none", app_cmd, app_addr);
      end else begin
        me = cmd_exp_q.pop_front();
        {me_t, me_a, me_b, me_d, me_m} = me;
        if (me_t)
          check("rd_cmd", {app_cmd, app_addr, app_burst_number}, {3'b001, me_a, me_b});
        else
          check("wr_cmd", {app_cmd, app_addr, app_burst_number, app_wdata_mask, app_wdata[31:0]},
                {3'b000, me_a, 6'd0, me_m, me_d[31:0]});
      end
    end
    if (rstn && app_wdata_en) check("wdata_end", app_wdata_end, 1'b1);
    if (rstn && io_fifo_rsp_valid && io_fifo_rsp_ready) begin
      if (rsp_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %0h, required none", io_fifo_rsp_data);
      end else begin
        check("rsp_data", io_fifo_rsp_data, rsp_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstn = 1'b0;
    io_fifo_cmd_valid = 1'b0; io_fifo_cmd_type = 1'b0; io_fifo_cmd_addr = '0;
    io_fifo_cmd_burst_cnt = '0; io_fifo_cmd_wt_data = '0; io_fifo_cmd_wt_mask = '0;
    io_fifo_rsp_ready = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
    app_cmd_rdy = 1'b1; app_wdata_rdy = 1'b1; init_calib_complete = 1'b1;
    cmd_exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic push_cmd(input logic t, input logic [26:0] a, input logic [5:0] b,
                          input logic [127:0] d, input logic [15:0] m, input bit exp_issue);
    bit ok;
    @(posedge clk); #1;
    io_fifo_cmd_valid = 1'b1; io_fifo_cmd_type = t; io_fifo_cmd_addr = a;
    io_fifo_cmd_burst_cnt = b; io_fifo_cmd_wt_data = d; io_fifo_cmd_wt_mask = m;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (io_fifo_cmd_ready) ok = 1'b1;
    end
    if (!ok) check("cmd_push_timeout", 1'b0, 1'b1);
    else begin
      fire_cyc = cyc;
      if (exp_issue) cmd_exp_q.push_back({t, a, b, d, m});
    end
    @(posedge clk); #1;
    io_fifo_cmd_valid = 1'b0;
  endtask

  task automatic wait_cmd_en(output int at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (app_cmd_en) begin ok = 1'b1; at = cyc; end
    end
    if (!ok) check("cmd_en_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_issued(input int target, input string name);
    for (int k = 0; k < 100 && n_issued < target; k++) @(negedge clk);
    check(name, n_issued, target);
  endtask

  task automatic send_beat(input logic [127:0] d, input bit exp_rsp);
    @(posedge clk); #1;
    app_rd_data_valid = 1'b1; app_rd_data = d;
    if (exp_rsp) rsp_exp_q.push_back(d);
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
  endtask

  task automatic wait_rsp_drain(input string name);
    for (int k = 0; k < 100 && rsp_exp_q.size() != 0; k++) @(negedge clk);
    check(name, rsp_exp_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  int t_en, base, hold;
  logic [127:0] beat;

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_flags", {io_fifo_cmd_ready, app_cmd_en, app_wdata_en, app_wdata_end,
          io_fifo_rsp_valid, busy, err}, 7'b1000000);
    check("reset_app", {app_cmd, app_addr, app_burst_number, app_wdata_mask}, '0);

    // 1: single write, latency and one-cycle strobes
    push_cmd(1'b0, 27'h0000120, 6'd5, {4{32'hA5A5A5A5}}, 16'h00FF, 1'b1);
    wait_cmd_en(t_en);
    check("wr_latency", t_en - fire_cyc, 2);
    check("wr_strobes", {app_cmd_en, app_wdata_en, app_wdata_end}, 3'b111);
    check("wr_mask", app_wdata_mask, 16'h00FF);
    @(negedge clk);
    check("wr_strobes_drop", {app_cmd_en, app_wdata_en}, 2'b00);

    // 2: read burst of 4, beats 5 cycles apart
    push_cmd(1'b1, 27'h40, 6'd3, '0, '0, 1'b1);
    wait_cmd_en(t_en);
    check("rd_latency", t_en - fire_cyc, 2);
    @(posedge clk); #1;
    app_rd_data_valid = 1'b1; app_rd_data = 128'h1000; rsp_exp_q.push_back(128'h1000);
    @(negedge clk);
`ifdef DDR_RD_BYPASS_EN
    check("rsp_lat_beat_cycle", io_fifo_rsp_valid, 1'b1);
`else
    check("rsp_lat_beat_cycle", io_fifo_rsp_valid, 1'b0);
`endif
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
    @(negedge clk);
`ifdef DDR_RD_BYPASS_EN
    check("rsp_lat_next_cycle", io_fifo_rsp_valid, 1'b0);
`else
    check("rsp_lat_next_cycle", io_fifo_rsp_valid, 1'b1);
`endif
    check("rd_busy_mid", busy, 1'b1);
    for (int i = 1; i < 4; i++) begin
      repeat (3) @(posedge clk);
      beat = 128'h1000 + 128'(i);
      send_beat(beat, 1'b1);
    end
    repeat (4) @(negedge clk);
    check("rd_busy_done", busy, 1'b0);
    wait_rsp_drain("rd_drain");

    // 3: credit blocks second read until a response beat is popped
    io_fifo_rsp_ready = 1'b0;
    base = n_issued;
    push_cmd(1'b1, 27'h80, 6'd7, '0, '0, 1'b1);
    push_cmd(1'b1, 27'hC0, 6'd0, '0, '0, 1'b1);
    wait_issued(base + 1, "credit_first_issue");
    for (int i = 0; i < 8; i++) begin
      beat = 128'h2000 + 128'(i);
      send_beat(beat, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("credit_block", n_issued, base + 1);
    @(posedge clk); #1 io_fifo_rsp_ready = 1'b1;
    @(posedge clk); #1 io_fifo_rsp_ready = 1'b0;
    wait_issued(base + 2, "credit_release");
    io_fifo_rsp_ready = 1'b1;
    send_beat(128'h2008, 1'b1);
    wait_rsp_drain("credit_drain");
    repeat (2) @(negedge clk);
    check("credit_idle", busy, 1'b0);

    // 4: delayed write-data ready, single pop, next command follows
    init_calib_complete = 1'b0;
    app_wdata_rdy = 1'b0;
    push_cmd(1'b0, 27'h200, 6'd0, 128'hDEAD0001, 16'h0F0F, 1'b1);
    push_cmd(1'b0, 27'h240, 6'd0, 128'hDEAD0002, 16'hF000, 1'b1);
    @(posedge clk); #1 init_calib_complete = 1'b1;
    wait_cmd_en(t_en);
    hold = 0;
    repeat (3) begin
      @(negedge clk);
      if (app_wdata_en && !app_cmd_en) hold++;
    end
    app_wdata_rdy = 1'b1;
    check("wdata_hold", hold, 3);
    @(negedge clk);
    check("wr_exit", {app_cmd_en, app_wdata_en}, 2'b00);
    @(negedge clk);
    check("next_cmd", {app_cmd_en, app_addr}, {1'b1, 27'h240});
    repeat (4) @(negedge clk);

    // 5: no issue before calibration, then four commands in order
    init_calib_complete = 1'b0;
    base = n_issued;
    for (int i = 0; i < 4; i++)
      push_cmd(1'b0, 27'h300 + 27'(i * 8), 6'd0, 128'(i + 7), 16'(i), 1'b1);
    @(negedge clk);
    check("cmd_full_ready", io_fifo_cmd_ready, 1'b0);
    repeat (5) @(negedge clk);
    check("no_issue_uncalib", n_issued, base);
    init_calib_complete = 1'b1;
    wait_issued(base + 4, "calib_issue_all");
    repeat (4) @(negedge clk);
    check("calib_busy_done", busy, 1'b0);

    // 6: reset during a read, then a stale beat
    app_cmd_rdy = 1'b0;
    push_cmd(1'b1, 27'h100, 6'd1, '0, '0, 1'b0);
    wait_cmd_en(t_en);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("post_reset", {err, app_cmd_en, busy}, 3'b000);
    @(posedge clk); #1;
    app_rd_data_valid = 1'b1; app_rd_data = 128'hBAD;
    @(negedge clk);
    check("stale_no_valid", io_fifo_rsp_valid, 1'b0);
    @(posedge clk); #1 app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("stale_err", {err, io_fifo_rsp_valid}, 2'b10);

    // 7: oversized read is dropped with error
    do_reset();
    base = n_issued;
    push_cmd(1'b1, 27'h500, 6'd8, '0, '0, 1'b0);
    repeat (5) @(negedge clk);
    check("oversize_err", {err, busy}, 2'b10);
    check("oversize_no_issue", n_issued, base);

    repeat (3) @(negedge clk);
    check("cmd_queue_empty", cmd_exp_q.size(), 0);
    check("rsp_queue_empty", rsp_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
